// File: rtl/vc_flow_ctrl.sv
// Flow controller for the MF -> VC0/VC1 -> D0/D1 path: latches thresholds, arbitrates
// FIFO pops under almost-full backpressure and registers the routed words into the next stage.
module vc_flow_ctrl #(
  parameter int unsigned DW = 6,
  parameter int unsigned MW = 2,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [MW-1:0] umbral_MF_in,
  input  logic [VW-1:0] umbral_VC0_in,
  input  logic [VW-1:0] umbral_VC1_in,
  input  logic [MW-1:0] umbral_D0_in,
  input  logic [MW-1:0] umbral_D1_in,
  output logic [MW-1:0] umbral_MF,
  output logic [VW-1:0] umbral_VC0,
  output logic [VW-1:0] umbral_VC1,
  output logic [MW-1:0] umbral_D0,
  output logic [MW-1:0] umbral_D1,
  input  logic          mf_empty,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic          d0_empty,
  input  logic          d1_empty,
  input  logic          vc0_afull,
  input  logic          vc1_afull,
  input  logic          d0_afull,
  input  logic          d1_afull,
  input  logic          fifo_err,
  input  logic [DW-1:0] mf_head,
  input  logic [DW-1:0] vc0_head,
  input  logic [DW-1:0] vc1_head,
  output logic          mf_pop,
  output logic          vc0_pop,
  output logic          vc1_pop,
  output logic          vc0_push,
  output logic          vc1_push,
  output logic [DW-1:0] vc_data,
  output logic          d0_push,
  output logic          d1_push,
  output logic [DW-1:0] d_data,
  output logic          active_out,
  output logic          idle_out,
  output logic          error_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic any_busy;
  logic inflight;
  logic load_thr;
  logic mf_tgt_afull;
  logic vc0_dst_afull;
  logic vc1_dst_afull;
  logic nxt_vc0_push;
  logic nxt_vc1_push;
  logic nxt_d0_push;
  logic nxt_d1_push;

  assign any_busy      = !(mf_empty && vc0_empty && vc1_empty && d0_empty && d1_empty);
  assign inflight      = vc0_push || vc1_push || d0_push || d1_push;
  assign load_thr      = init && (next_state == S_INIT);
  // Backpressure is judged against the FIFO each head word is routed to.
  assign mf_tgt_afull  = mf_head[DW-1]  ? vc1_afull : vc0_afull;
  assign vc0_dst_afull = vc0_head[DW-2] ? d1_afull  : d0_afull;
  assign vc1_dst_afull = vc1_head[DW-2] ? d1_afull  : d0_afull;

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= S_RESET;
    else          state <= next_state;
  end

  // Next-state logic; error is sticky and outranks init
  always_comb begin
    next_state = state;
    case (state)
      S_RESET:  next_state = S_INIT;
      S_INIT:   next_state = fifo_err ? S_ERROR : (init ? S_INIT : S_IDLE);
      S_IDLE: begin
        if (fifo_err)      next_state = S_ERROR;
        else if (init)     next_state = S_INIT;
        else if (any_busy) next_state = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (fifo_err)                   next_state = S_ERROR;
        else if (init)                  next_state = S_INIT;
        else if (!any_busy && !inflight) next_state = S_IDLE;
      end
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_RESET;
    endcase
  end

  // Pop arbitration and next-cycle push selection; VC0 has strict priority into D
  always_comb begin
    mf_pop  = 1'b0;
    vc0_pop = 1'b0;
    vc1_pop = 1'b0;
    if (state == S_IDLE || state == S_ACTIVE) begin
      mf_pop  = !mf_empty && !mf_tgt_afull;
      vc0_pop = !vc0_empty && !vc0_dst_afull;
      vc1_pop = !vc0_pop && !vc1_empty && !vc1_dst_afull;
    end
    nxt_vc0_push = mf_pop && !mf_head[DW-1];
    nxt_vc1_push = mf_pop && mf_head[DW-1];
    nxt_d0_push  = (vc0_pop && !vc0_head[DW-2]) || (vc1_pop && !vc1_head[DW-2]);
    nxt_d1_push  = (vc0_pop && vc0_head[DW-2])  || (vc1_pop && vc1_head[DW-2]);
  end

  // Registered pushes, data, status flags and latched thresholds
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vc0_push   <= 1'b0;
      vc1_push   <= 1'b0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
      vc_data    <= '0;
      d_data     <= '0;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      umbral_MF  <= '0;
      umbral_VC0 <= '0;
      umbral_VC1 <= '0;
      umbral_D0  <= '0;
      umbral_D1  <= '0;
    end else begin
      vc0_push   <= nxt_vc0_push;
      vc1_push   <= nxt_vc1_push;
      d0_push    <= nxt_d0_push;
      d1_push    <= nxt_d1_push;
      if (mf_pop) vc_data <= mf_head;
      if (vc0_pop)      d_data <= vc0_head;
      else if (vc1_pop) d_data <= vc1_head;
      idle_out   <= (next_state == S_IDLE);
      active_out <= (next_state == S_ACTIVE);
      error_out  <= (next_state == S_ERROR);
      if (load_thr) begin
        umbral_MF  <= umbral_MF_in;
        umbral_VC0 <= umbral_VC0_in;
        umbral_VC1 <= umbral_VC1_in;
        umbral_D0  <= umbral_D0_in;
        umbral_D1  <= umbral_D1_in;
      end
    end
  end

endmodule

// File: tb/tb_vc_flow_ctrl.sv
// Bench for vc_flow_ctrl: a mode-level model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_vc_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       init = 1'b0;
  logic [1:0] umbral_MF_in = '0;
  logic [3:0] umbral_VC0_in = '0;
  logic [3:0] umbral_VC1_in = '0;
  logic [1:0] umbral_D0_in = '0;
  logic [1:0] umbral_D1_in = '0;
  logic [1:0] umbral_MF;
  logic [3:0] umbral_VC0;
  logic [3:0] umbral_VC1;
  logic [1:0] umbral_D0;
  logic [1:0] umbral_D1;
  logic mf_empty = 1'b1, vc0_empty = 1'b1, vc1_empty = 1'b1, d0_empty = 1'b1, d1_empty = 1'b1;
  logic vc0_afull = 1'b0, vc1_afull = 1'b0, d0_afull = 1'b0, d1_afull = 1'b0;
  logic fifo_err = 1'b0;
  logic [5:0] mf_head = '0, vc0_head = '0, vc1_head = '0;
  logic mf_pop, vc0_pop, vc1_pop;
  logic vc0_push, vc1_push, d0_push, d1_push;
  logic [5:0] vc_data, d_data;
  logic active_out, idle_out, error_out;

  int n_chk = 0;
  int n_pass = 0;

  vc_flow_ctrl dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_MF_in(umbral_MF_in), .umbral_VC0_in(umbral_VC0_in), .umbral_VC1_in(umbral_VC1_in),
    .umbral_D0_in(umbral_D0_in), .umbral_D1_in(umbral_D1_in),
    .umbral_MF(umbral_MF), .umbral_VC0(umbral_VC0), .umbral_VC1(umbral_VC1),
    .umbral_D0(umbral_D0), .umbral_D1(umbral_D1),
    .mf_empty(mf_empty), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .d0_empty(d0_empty), .d1_empty(d1_empty),
    .vc0_afull(vc0_afull), .vc1_afull(vc1_afull), .d0_afull(d0_afull), .d1_afull(d1_afull),
    .fifo_err(fifo_err), .mf_head(mf_head), .vc0_head(vc0_head), .vc1_head(vc1_head),
    .mf_pop(mf_pop), .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .vc0_push(vc0_push), .vc1_push(vc1_push), .vc_data(vc_data),
    .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;
  int m_mode = M_RESET;
  logic m_vc0_push = 0, m_vc1_push = 0, m_d0_push = 0, m_d1_push = 0;
  logic [5:0] m_vc_data = '0, m_d_data = '0;
  logic [1:0] m_thr_mf = '0, m_thr_d0 = '0, m_thr_d1 = '0;
  logic [3:0] m_thr_vc0 = '0, m_thr_vc1 = '0;

  // {mf, vc0, vc1} pops the rules allow this cycle
  function automatic logic [2:0] exp_pops();
    logic ok, pm, p0, p1;
    ok = (m_mode == M_IDLE) || (m_mode == M_ACTIVE);
    pm = ok && !mf_empty && !(mf_head[5] ? vc1_afull : vc0_afull);
    p0 = ok && !vc0_empty && !(vc0_head[4] ? d1_afull : d0_afull);
    p1 = ok && !p0 && !vc1_empty && !(vc1_head[4] ? d1_afull : d0_afull);
    return {pm, p0, p1};
  endfunction

  function automatic int next_mode();
    logic busy, flight;
    busy   = !(mf_empty && vc0_empty && vc1_empty && d0_empty && d1_empty);
    flight = m_vc0_push || m_vc1_push || m_d0_push || m_d1_push;
    if (m_mode == M_RESET) return M_INIT;
    if (m_mode == M_ERROR || fifo_err) return M_ERROR;
    if (init) return M_INIT;
    if (m_mode == M_INIT) return M_IDLE;
    if (busy || (m_mode == M_ACTIVE && flight)) return M_ACTIVE;
    return M_IDLE;
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_mode <= M_RESET;
      m_vc0_push <= 0; m_vc1_push <= 0; m_d0_push <= 0; m_d1_push <= 0;
      m_vc_data <= '0; m_d_data <= '0;
      m_thr_mf <= '0; m_thr_vc0 <= '0; m_thr_vc1 <= '0; m_thr_d0 <= '0; m_thr_d1 <= '0;
    end else begin : model_step
      logic [2:0] p;
      p = exp_pops();
      m_mode     <= next_mode();
      m_vc0_push <= p[2] && (mf_head[5] == 1'b0);
      m_vc1_push <= p[2] && (mf_head[5] == 1'b1);
      m_d0_push  <= (p[1] && !vc0_head[4]) || (p[0] && !vc1_head[4]);
      m_d1_push  <= (p[1] && vc0_head[4]) || (p[0] && vc1_head[4]);
      if (p[2]) m_vc_data <= mf_head;
      if (p[1]) m_d_data <= vc0_head;
      else if (p[0]) m_d_data <= vc1_head;
      if (init && next_mode() == M_INIT) begin
        m_thr_mf <= umbral_MF_in; m_thr_vc0 <= umbral_VC0_in; m_thr_vc1 <= umbral_VC1_in;
        m_thr_d0 <= umbral_D0_in; m_thr_d1 <= umbral_D1_in;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [2:0] p;
    p = exp_pops();
    chk("mf_pop", 8'(mf_pop), 8'(p[2]));
    chk("vc0_pop", 8'(vc0_pop), 8'(p[1]));
    chk("vc1_pop", 8'(vc1_pop), 8'(p[0]));
    chk("vc0_push", 8'(vc0_push), 8'(m_vc0_push));
    chk("vc1_push", 8'(vc1_push), 8'(m_vc1_push));
    chk("d0_push", 8'(d0_push), 8'(m_d0_push));
    chk("d1_push", 8'(d1_push), 8'(m_d1_push));
    if (m_vc0_push || m_vc1_push) chk("vc_data", 8'(vc_data), 8'(m_vc_data));
    if (m_d0_push || m_d1_push) chk("d_data", 8'(d_data), 8'(m_d_data));
    chk("idle_out", 8'(idle_out), 8'(m_mode == M_IDLE));
    chk("active_out", 8'(active_out), 8'(m_mode == M_ACTIVE));
    chk("error_out", 8'(error_out), 8'(m_mode == M_ERROR));
    chk("umbral_MF", 8'(umbral_MF), 8'(m_thr_mf));
    chk("umbral_VC0", 8'(umbral_VC0), 8'(m_thr_vc0));
    chk("umbral_VC1", 8'(umbral_VC1), 8'(m_thr_vc1));
    chk("umbral_D0", 8'(umbral_D0), 8'(m_thr_d0));
    chk("umbral_D1", 8'(umbral_D1), 8'(m_thr_d1));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_inputs();
    mf_empty = 1; vc0_empty = 1; vc1_empty = 1; d0_empty = 1; d1_empty = 1;
    vc0_afull = 0; vc1_afull = 0; d0_afull = 0; d1_afull = 0;
    fifo_err = 0; mf_head = '0; vc0_head = '0; vc1_head = '0;
  endtask

  initial begin
    #1 reset_L = 0;
    tick(); tick();
    chk("rst idle", 8'(idle_out), 8'd0);
    chk("rst error", 8'(error_out), 8'd0);
    chk("rst umbral_VC0", 8'(umbral_VC0), 8'd0);

    // Init: load thresholds, then drop to IDLE
    init = 1; umbral_VC0_in = 4'hA; umbral_VC1_in = 4'h5;
    umbral_MF_in = 2'd2; umbral_D0_in = 2'd1; umbral_D1_in = 2'd3;
    reset_L = 1;
    tick(); tick();
    chk("init umbral_VC0", 8'(umbral_VC0), 8'h0A);
    chk("init umbral_D1", 8'(umbral_D1), 8'd3);
    chk("init idle", 8'(idle_out), 8'd0);
    init = 0;
    tick();
    chk("idle after init", 8'(idle_out), 8'd1);

    // MF stream 0x1B,0x2D,0x03
    mf_empty = 0; mf_head = 6'h1B;
    #1 chk("mf_pop 1B", 8'(mf_pop), 8'd1);
    tick();
    chk("vc0_push 1B", 8'(vc0_push), 8'd1);
    chk("vc_data 1B", 8'(vc_data), 8'h1B);
    chk("active", 8'(active_out), 8'd1);
    mf_head = 6'h2D;
    tick();
    chk("vc1_push 2D", 8'(vc1_push), 8'd1);
    chk("vc0_push off", 8'(vc0_push), 8'd0);
    chk("vc_data 2D", 8'(vc_data), 8'h2D);
    mf_head = 6'h03;
    tick();
    chk("vc0_push 03", 8'(vc0_push), 8'd1);
    chk("vc_data 03", 8'(vc_data), 8'h03);
    mf_empty = 1;
    tick();

    // VC0 priority over VC1, both to D1
    vc0_empty = 0; vc0_head = 6'h1B; vc1_empty = 0; vc1_head = 6'h3B;
    #1 chk("prio vc0_pop", 8'(vc0_pop), 8'd1);
    chk("prio vc1_pop", 8'(vc1_pop), 8'd0);
    tick();
    chk("d1_push 1B", 8'(d1_push), 8'd1);
    chk("d_data 1B", 8'(d_data), 8'h1B);
    vc0_empty = 1;
    #1 chk("vc1_pop after vc0", 8'(vc1_pop), 8'd1);
    tick();
    chk("d_data 3B", 8'(d_data), 8'h3B);

    // D1 backpressure lets VC1 through to D0
    vc0_empty = 0; vc0_head = 6'h1A; vc1_head = 6'h0A; d1_afull = 1;
    #1 chk("bp vc0_pop", 8'(vc0_pop), 8'd0);
    chk("bp vc1_pop", 8'(vc1_pop), 8'd1);
    tick();
    chk("d0_push 0A", 8'(d0_push), 8'd1);
    chk("d1_push off", 8'(d1_push), 8'd0);
    chk("d_data 0A", 8'(d_data), 8'h0A);

    // VC almost-full blocks MF pops to that VC only
    vc0_empty = 1; vc1_empty = 1; d1_afull = 0;
    mf_empty = 0; mf_head = 6'h2D; vc1_afull = 1;
    #1 chk("vc1 afull blocks", 8'(mf_pop), 8'd0);
    mf_head = 6'h1B;
    #1 chk("vc0 free pops", 8'(mf_pop), 8'd1);

    // Drain: in-flight push keeps ACTIVE for one more edge
    quiet_inputs();
    tick();
    chk("drain d0_push", 8'(d0_push), 8'd0);
    chk("drain still active", 8'(active_out), 8'd1);
    tick();
    chk("drain idle", 8'(idle_out), 8'd1);
    chk("drain active off", 8'(active_out), 8'd0);

    // Error is sticky, blocks pops and ignores init
    mf_empty = 0; mf_head = 6'h1B; vc0_afull = 1;
    tick();
    chk("err pre active", 8'(active_out), 8'd1);
    fifo_err = 1;
    tick();
    chk("error_out", 8'(error_out), 8'd1);
    chk("err active off", 8'(active_out), 8'd0);
    fifo_err = 0; vc0_afull = 0; init = 1; umbral_VC0_in = 4'h3;
    #1 chk("err no pop", 8'(mf_pop), 8'd0);
    tick();
    chk("err sticky", 8'(error_out), 8'd1);
    chk("err no reload", 8'(umbral_VC0), 8'h0A);
    #3 reset_L = 0;
    #1 chk("async clr error", 8'(error_out), 8'd0);
    chk("async clr thr", 8'(umbral_VC0), 8'd0);

    init = 0; quiet_inputs();
    tick();
    reset_L = 1;
    tick(); tick();
    chk("re-idle", 8'(idle_out), 8'd1);
    chk("re-idle thr", 8'(umbral_VC0), 8'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
